// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: opcodes, funct fields, ALU-op and immediate-format enums,
// and the canonical NOP word. Used by the decode stage and its testbench.
package rv32i_pkg;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_COPYB
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    function automatic logic [31:0] gen_imm(input imm_fmt_e fmt, input logic [31:0] inst);
        case (fmt)
            IMM_I:   return {{20{inst[31]}}, inst[31:20]};
            IMM_S:   return {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   return {inst[31:12], 12'b0};
            IMM_J:   return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 register file: two combinational reads, one write, x0 hardwired to zero.
// Optional same-cycle write-through when WB_BYPASS_EN is defined.
module regfile_2r1w (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wen,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr_a,
    output logic [31:0] o_rdata_a,
    input  logic [4:0]  i_raddr_b,
    output logic [31:0] o_rdata_b
);

    logic [31:0] r_mem [32];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wen && (i_waddr != 5'd0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

`ifdef WB_BYPASS_EN
    logic w_hit_a;
    logic w_hit_b;
    assign w_hit_a = i_wen && (i_waddr == i_raddr_a);
    assign w_hit_b = i_wen && (i_waddr == i_raddr_b);
    assign o_rdata_a = (i_raddr_a == 5'd0) ? 32'h0 : (w_hit_a ? i_wdata : r_mem[i_raddr_a]);
    assign o_rdata_b = (i_raddr_b == 5'd0) ? 32'h0 : (w_hit_b ? i_wdata : r_mem[i_raddr_b]);
`else
    assign o_rdata_a = (i_raddr_a == 5'd0) ? 32'h0 : r_mem[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == 5'd0) ? 32'h0 : r_mem[i_raddr_b];
`endif

endmodule

// File: rtl/id_stage.sv
// RV32I instruction decode stage: IF/ID register, decoder, immediate generator and branch unit.
// WB_BYPASS_EN selects register-file write-through for same-cycle writeback reads.
module id_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h00000000,
    parameter logic [31:0] NOP_INST   = 32'h00000013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_inst_valid,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_fetch_pc,
    input  logic        i_stall_if_id,
    input  logic        i_flush_id,
    input  logic        i_wb_wen,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_wdata,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    output logic [31:0] o_imm,
    output logic [3:0]  o_alu_op,
    output logic        o_alu_src_imm,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [2:0]  o_mem_funct3,
    output logic        o_reg_wen,
    output logic        o_illegal,
    output logic        o_pc_redirect,
    output logic [31:0] o_pc_redirect_target
);

    import rv32i_pkg::*;

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_inst;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    imm_fmt_e    w_fmt;
    alu_op_e     w_alu_op;
    logic        w_has_rs1, w_has_rs2, w_has_rd;
    logic        w_src_imm, w_load, w_store, w_branch, w_jal, w_jalr, w_bad;
    logic        w_taken, w_ok;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [31:0] w_imm, w_rs1_data, w_rs2_data, w_sum;

    // A taken redirect squashes the word fetch offered in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= RESET_ADDR;
            r_inst  <= NOP_INST;
        end else if (i_flush_id || o_pc_redirect) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
        end else if (!i_stall_if_id) begin
            if (i_inst_valid) begin
                r_valid <= 1'b1;
                r_pc    <= i_fetch_pc;
                r_inst  <= i_inst;
            end else begin
                r_valid <= 1'b0;
                r_inst  <= NOP_INST;
            end
        end
    end

    assign w_opcode = r_inst[6:0];
    assign w_funct3 = r_inst[14:12];
    assign w_funct7 = r_inst[31:25];

    always_comb begin
        w_fmt     = IMM_NONE;
        w_alu_op  = ALU_ADD;
        w_has_rs1 = 1'b0;
        w_has_rs2 = 1'b0;
        w_has_rd  = 1'b0;
        w_src_imm = 1'b1;
        w_load    = 1'b0;
        w_store   = 1'b0;
        w_branch  = 1'b0;
        w_jal     = 1'b0;
        w_jalr    = 1'b0;
        w_bad     = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_fmt = IMM_U; w_has_rd = 1'b1; w_alu_op = ALU_COPYB;
            end
            OPC_AUIPC: begin
                w_fmt = IMM_U; w_has_rd = 1'b1;
            end
            OPC_JAL: begin
                w_fmt = IMM_J; w_has_rd = 1'b1; w_jal = 1'b1;
            end
            OPC_JALR: begin
                w_fmt = IMM_I; w_has_rd = 1'b1; w_has_rs1 = 1'b1; w_jalr = 1'b1;
            end
            OPC_BRANCH: begin
                w_fmt = IMM_B; w_has_rs1 = 1'b1; w_has_rs2 = 1'b1;
                w_branch = 1'b1; w_src_imm = 1'b0; w_alu_op = ALU_SUB;
                w_bad = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            end
            OPC_LOAD: begin
                w_fmt = IMM_I; w_has_rd = 1'b1; w_has_rs1 = 1'b1; w_load = 1'b1;
                w_bad = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
            end
            OPC_STORE: begin
                w_fmt = IMM_S; w_has_rs1 = 1'b1; w_has_rs2 = 1'b1; w_store = 1'b1;
                w_bad = (w_funct3 > 3'b010);
            end
            OPC_OPIMM: begin
                w_fmt = IMM_I; w_has_rd = 1'b1; w_has_rs1 = 1'b1;
                case (w_funct3)
                    3'b000: w_alu_op = ALU_ADD;
                    3'b001: begin w_alu_op = ALU_SLL; w_bad = (w_funct7 != F7_BASE); end
                    3'b010: w_alu_op = ALU_SLT;
                    3'b011: w_alu_op = ALU_SLTU;
                    3'b100: w_alu_op = ALU_XOR;
                    3'b101: begin
                        w_alu_op = w_funct7[5] ? ALU_SRA : ALU_SRL;
                        w_bad    = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
                    end
                    3'b110: w_alu_op = ALU_OR;
                    default: w_alu_op = ALU_AND;
                endcase
            end
            OPC_OP: begin
                w_has_rd = 1'b1; w_has_rs1 = 1'b1; w_has_rs2 = 1'b1; w_src_imm = 1'b0;
                w_bad = !((w_funct7 == F7_BASE) ||
                          ((w_funct7 == F7_ALT) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
                case (w_funct3)
                    3'b000: w_alu_op = w_funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001: w_alu_op = ALU_SLL;
                    3'b010: w_alu_op = ALU_SLT;
                    3'b011: w_alu_op = ALU_SLTU;
                    3'b100: w_alu_op = ALU_XOR;
                    3'b101: w_alu_op = w_funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110: w_alu_op = ALU_OR;
                    default: w_alu_op = ALU_AND;
                endcase
            end
            OPC_FENCE, OPC_SYSTEM: begin
            end
            default: w_bad = 1'b1;
        endcase
    end

    assign w_rs1 = w_has_rs1 ? r_inst[19:15] : 5'd0;
    assign w_rs2 = w_has_rs2 ? r_inst[24:20] : 5'd0;
    assign w_rd  = w_has_rd  ? r_inst[11:7]  : 5'd0;
    assign w_imm = gen_imm(w_fmt, r_inst);

    regfile_2r1w u_regfile (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wen     (i_wb_wen),
        .i_waddr   (i_wb_rd),
        .i_wdata   (i_wb_wdata),
        .i_raddr_a (w_rs1),
        .o_rdata_a (w_rs1_data),
        .i_raddr_b (w_rs2),
        .o_rdata_b (w_rs2_data)
    );

    always_comb begin
        w_taken = 1'b0;
        if (w_jal || w_jalr) begin
            w_taken = 1'b1;
        end else if (w_branch) begin
            case (w_funct3)
                F3_BEQ:  w_taken = (w_rs1_data == w_rs2_data);
                F3_BNE:  w_taken = (w_rs1_data != w_rs2_data);
                F3_BLT:  w_taken = ($signed(w_rs1_data) <  $signed(w_rs2_data));
                F3_BGE:  w_taken = ($signed(w_rs1_data) >= $signed(w_rs2_data));
                F3_BLTU: w_taken = (w_rs1_data <  w_rs2_data);
                F3_BGEU: w_taken = (w_rs1_data >= w_rs2_data);
                default: w_taken = 1'b0;
            endcase
        end
    end

    assign w_sum = (w_jalr ? w_rs1_data : r_pc) + w_imm;
    assign w_ok  = r_valid && !w_bad;

    assign o_valid              = r_valid;
    assign o_pc                 = r_pc;
    assign o_inst               = r_inst;
    assign o_rs1                = w_rs1;
    assign o_rs2                = w_rs2;
    assign o_rd                 = w_rd;
    assign o_rs1_data           = w_rs1_data;
    assign o_rs2_data           = w_rs2_data;
    assign o_imm                = w_imm;
    assign o_alu_op             = w_alu_op;
    assign o_alu_src_imm        = w_src_imm;
    assign o_mem_ren            = w_ok && w_load;
    assign o_mem_wen            = w_ok && w_store;
    assign o_mem_funct3         = (w_load || w_store) ? w_funct3 : 3'b000;
    assign o_reg_wen            = w_ok && w_has_rd && (w_rd != 5'd0);
    assign o_illegal            = r_valid && w_bad;
    assign o_pc_redirect        = w_ok && w_taken && !i_stall_if_id;
    assign o_pc_redirect_target = w_jalr ? (w_sum & ~32'h1) : w_sum;

endmodule
